// File: rtl/mc_controller_v2.sv
// Multicycle RISC-V main controller: one-hot-free encoded FSM with combinational
// datapath controls, optional bne/jalr support and optional memory handshake.
module mc_controller_v2 #(
    parameter int SUPPORT_BNE   = 1,
    parameter int SUPPORT_JALR  = 1,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       MemWrite_o,
    output logic       MemRead_o,
    output logic       IRWrite_o,
    output logic       RegWrite_o,
    output logic       AdrSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ResultSrc_o,
    output logic [2:0] ALUControl_o,
    output logic [2:0] ImmSrc_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_LUI      = 4'd11,
        S_JALR1    = 4'd12,
        S_JALR2    = 4'd13,
        S_ERROR    = 4'd15
    } state_t;

    state_t state;
    logic   mem_rdy;
    logic   alu_funct_ok;
    logic   branch_ok;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7,
                                              input logic op5);
        logic [2:0] alu;
        case (f3)
            3'b000:  alu = (f7 && op5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu = ALU_SLT;
            3'b110:  alu = ALU_OR;
            3'b111:  alu = ALU_AND;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

    assign mem_rdy      = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;
    assign alu_funct_ok = (funct3_i == 3'b000) || (funct3_i == 3'b010) ||
                          (funct3_i == 3'b110) || (funct3_i == 3'b111);
    assign branch_ok    = (funct3_i == 3'b000) ||
                          ((funct3_i == 3'b001) && (SUPPORT_BNE != 0));
    assign state_o      = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_rdy) state <= S_DECODE;
                S_DECODE: begin
                    case (op_i)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= alu_funct_ok ? S_EXECR : S_ERROR;
                        OP_I:         state <= alu_funct_ok ? S_EXECI : S_ERROR;
                        OP_JAL:       state <= S_JAL;
                        OP_BR:        state <= branch_ok ? S_BRANCH : S_ERROR;
                        OP_LUI:       state <= S_LUI;
                        OP_JALR:      state <= (SUPPORT_JALR != 0) ? S_JALR1 : S_ERROR;
                        default:      state <= S_ERROR;
                    endcase
                end
                S_MEMADR:   state <= (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_rdy) state <= S_MEMWB;
                S_MEMWRITE: if (mem_rdy) state <= S_FETCH;
                S_MEMWB, S_ALUWB, S_BRANCH, S_LUI: state <= S_FETCH;
                S_EXECR, S_EXECI, S_JAL, S_JALR2:  state <= S_ALUWB;
                S_JALR1:    state <= S_JALR2;
                S_ERROR:    state <= S_ERROR;
                default:    state <= S_ERROR;
            endcase
        end
    end

    always_comb begin
        case (op_i)
            OP_SW:   ImmSrc_o = 3'b001;
            OP_BR:   ImmSrc_o = 3'b010;
            OP_JAL:  ImmSrc_o = 3'b011;
            OP_LUI:  ImmSrc_o = 3'b100;
            default: ImmSrc_o = 3'b000;
        endcase
    end

    always_comb begin
        PCWrite_o    = 1'b0;
        MemWrite_o   = 1'b0;
        MemRead_o    = 1'b0;
        IRWrite_o    = 1'b0;
        RegWrite_o   = 1'b0;
        AdrSrc_o     = 1'b0;
        ALUSrcA_o    = 2'b00;
        ALUSrcB_o    = 2'b00;
        ResultSrc_o  = 2'b00;
        ALUControl_o = ALU_ADD;
        case (state)
            S_FETCH: begin
                MemRead_o   = 1'b1;
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b10;
                IRWrite_o   = mem_rdy;
                PCWrite_o   = mem_rdy;
            end
            S_DECODE: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b01;
            end
            S_MEMADR, S_JALR1: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc_o  = 1'b1;
                MemRead_o = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc_o = 2'b01;
                RegWrite_o  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc_o   = 1'b1;
                MemWrite_o = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA_o    = 2'b10;
                ALUControl_o = alu_decode(funct3_i, funct7_i, op_i[5]);
            end
            S_EXECI: begin
                ALUSrcA_o    = 2'b10;
                ALUSrcB_o    = 2'b01;
                ALUControl_o = alu_decode(funct3_i, funct7_i, op_i[5]);
            end
            S_ALUWB:   RegWrite_o = 1'b1;
            S_JAL, S_JALR2: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b10;
                PCWrite_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o    = 2'b10;
                ALUControl_o = ALU_SUB;
                PCWrite_o    = (funct3_i == 3'b000) ? zero_i :
                               (funct3_i == 3'b001) ? !zero_i : 1'b0;
            end
            S_LUI: begin
                ResultSrc_o = 2'b11;
                RegWrite_o  = 1'b1;
            end
            default: ;
        endcase
        // Reset masks every enable regardless of where the state register sits.
        if (!reset) begin
            PCWrite_o  = 1'b0;
            MemWrite_o = 1'b0;
            MemRead_o  = 1'b0;
            IRWrite_o  = 1'b0;
            RegWrite_o = 1'b0;
        end
    end

    assign illegal_o = (state == S_ERROR) && reset;

endmodule

// File: doc/mc_controller_v2.md
MC_CONTROLLER_V2 -- requirements
Module: mc_controller_v2

Interface
REQ-001 Param SUPPORT_BNE, default 1: 1 = bne (funct3 001) legal; 0 = bne illegal.
REQ-002 Param SUPPORT_JALR, default 1: 1 = jalr (op 1100111) legal; 0 = jalr illegal.
REQ-003 Param MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready_i; 0 = mem_ready_i treated as constant 1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low (0 = reset), sampled on rising clk.
REQ-006 op_i 7 / funct3_i 3 / funct7_i 1 (instr bit 30) / zero_i 1 / mem_ready_i 1  in  instruction fields, ALU zero flag, memory done.
REQ-007 PCWrite_o, MemWrite_o, MemRead_o, IRWrite_o, RegWrite_o  out  1 each  write enables and memory read request.
REQ-008 AdrSrc_o 1, ALUSrcA_o 2, ALUSrcB_o 2, ResultSrc_o 2, ALUControl_o 3, ImmSrc_o 3  out  datapath selects.
REQ-009 illegal_o  out  1  sticky illegal-instruction flag; state_o  out  4  current state code.

Function
REQ-010 Outputs SHALL be combinational from the registered state, op_i, funct3_i, funct7_i, zero_i and mem_ready_i; state is the only FSM storage.
REQ-011 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10, LUI 11, JALR1 12, JALR2 13, ERROR 15; state_o equals the code.
REQ-012 ImmSrc_o SHALL be a function of op_i only: lw/I-ALU/jalr 000, sw 001, branch 010, jal 011, lui 100, else 000.
REQ-013 ALUControl: add 000, sub 001, and 010, or 011, slt 101; funct decode: funct3 000 -> sub if funct7_i&op_i[5], else add; 010 slt; 110 or; 111 and.
REQ-014 Unlisted selects SHALL be 0 in every state; unlisted enables SHALL be 0.
REQ-015 FETCH: AdrSrc 0, MemRead 1, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10; IRWrite and PCWrite = ready; stay if !ready, else DECODE.
REQ-016 DECODE: ALUSrcA 01, ALUSrcB 01, add. Next: lw/sw MEMADR, R EXECR, I-ALU EXECI, jal JAL, branch BRANCH, lui LUI, jalr JALR1.
REQ-017 DECODE SHALL go to ERROR for: unknown opcode; R/I-ALU funct3 not in {000,010,110,111}; branch funct3 not 000 (or 001 with SUPPORT_BNE=1); jalr with SUPPORT_JALR=0.
REQ-018 MEMADR: ALUSrcA 10, ALUSrcB 01, add; next MEMREAD (lw) or MEMWRITE (sw).
REQ-019 MEMREAD: AdrSrc 1, MemRead 1; stay while !ready, else MEMWB.
REQ-020 MEMWB: ResultSrc 01, RegWrite 1; next FETCH.
REQ-021 MEMWRITE: AdrSrc 1, MemWrite 1 held until ready; stay while !ready, else FETCH.
REQ-022 EXECR: ALUSrcA 10, ALUSrcB 00, funct decode; EXECI: ALUSrcA 10, ALUSrcB 01, funct decode; both next ALUWB.
REQ-023 ALUWB: ResultSrc 00, RegWrite 1; next FETCH.
REQ-024 JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite 1; next ALUWB.
REQ-025 JALR1: ALUSrcA 10, ALUSrcB 01, add; next JALR2. JALR2: identical controls to JAL; next ALUWB.
REQ-026 BRANCH: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00; PCWrite = zero_i (funct3 000) or !zero_i (funct3 001); next FETCH.
REQ-027 LUI: ResultSrc 11, RegWrite 1; next FETCH.
REQ-028 ERROR: all enables 0, illegal_o 1; remains in ERROR until reset.
REQ-029 illegal_o SHALL be 1 only in ERROR.
REQ-030 mem_ready_i SHALL be ignored outside FETCH, MEMREAD, MEMWRITE.

Reset
REQ-031 reset=0 at a rising edge SHALL load FETCH, overriding any transition, including mid-wait or ERROR.
REQ-032 While reset=0, all enables SHALL be forced 0 combinationally and illegal_o SHALL be 0.
REQ-033 First cycle with reset=1 SHALL be FETCH.

Verification
REQ-034 lw (0000011), ready=1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; RegWrite 1 only in MEMWB with ResultSrc 01.
REQ-035 sw, ready low 3 cycles in MEMWRITE -> MemWrite 1 for 4 cycles, state 5 held, then FETCH.
REQ-036 R-type sub (funct3 000, funct7 1) -> ALUControl 001 in EXECR; I-type addi with funct7 bit 1 -> 000.
REQ-037 bne zero_i=0 -> PCWrite 1 in BRANCH; SUPPORT_BNE=0 -> ERROR (15), illegal_o 1, held until reset=0.
REQ-038 jalr -> JALR1, JALR2 (PCWrite 1), ALUWB (RegWrite 1), FETCH; ImmSrc 000 throughout.
REQ-039 Opcode 0000000 -> ERROR; reset=0 mid-FETCH-wait -> FETCH next edge, enables 0 during reset.
